// File: rtl/shift_issue_pkg.sv
// Shared command type and direction/fill encodings for the shift issue stage.
// Latency: n/a (types only). Backpressure: n/a.
// Optional stats build: SHIFT_ISSUE_STATS_EN.
package shift_issue_pkg;

  typedef struct packed {
    logic [7:0] din;
    logic [2:0] shamt;
    logic       lr;
    logic       al;
  } shift_cmd_t;

  localparam logic DIR_RIGHT  = 1'b0;
  localparam logic DIR_LEFT   = 1'b1;
  localparam logic FILL_LOGIC = 1'b0;
  localparam logic FILL_ARITH = 1'b1;

  // Driven onto the shifter whenever no command is queued.
  localparam shift_cmd_t IDLE_CMD = '{din: 8'h00, shamt: 3'd0, lr: DIR_RIGHT, al: FILL_LOGIC};

endpackage

// File: rtl/shift_cmd_fifo.sv
// Circular command FIFO, DEPTH entries, pointers carry an extra wrap bit.
// Latency: a push is visible at head the cycle after it is written (no bypass).
// Backpressure: push ignored while full, pop ignored while empty.
module shift_cmd_fifo
  import shift_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  shift_cmd_t push_dat,
  input  logic       pop,
  output shift_cmd_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  shift_cmd_t  r_mem [DEPTH];
  logic        w_push;
  logic        w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_dat;
  end

  assign head  = r_mem[r_rd_ptr[AW-1:0]];
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/shift_issue_stage.sv
// Command FIFO + result register around an external combinational barrel shifter.
// Latency: 2 cycles from command acceptance to res_valid; 1 result/cycle while res_ready=1.
// Backpressure: res_ready=0 holds the result and lets the FIFO fill; in_ready = !full. Stats: SHIFT_ISSUE_STATS_EN.
module shift_issue_stage
  import shift_issue_pkg::*;
#(
  parameter int DEPTH = 4
`ifdef SHIFT_ISSUE_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_din,
  input  logic [2:0] in_shamt,
  input  logic       in_lr,
  input  logic       in_al,
  output logic [7:0] sh_din,
  output logic [2:0] sh_shamt,
  output logic       sh_lr,
  output logic       sh_al,
  input  logic [7:0] sh_dout,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data
`ifdef SHIFT_ISSUE_STATS_EN
  , output logic [CNT_W-1:0] issue_cnt
`endif
);

  shift_cmd_t w_push_cmd;
  shift_cmd_t w_head;
  shift_cmd_t w_sh_cmd;
  logic       w_full;
  logic       w_empty;
  logic       w_issue;
  logic       r_res_valid;
  logic [7:0] r_res_data;

  assign w_push_cmd = '{din: in_din, shamt: in_shamt, lr: in_lr, al: in_al};
  assign in_ready   = !w_full;

  shift_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (in_valid),
    .push_dat (w_push_cmd),
    .pop      (w_issue),
    .head     (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

  assign w_sh_cmd = w_empty ? IDLE_CMD : w_head;
  assign sh_din   = w_sh_cmd.din;
  assign sh_shamt = w_sh_cmd.shamt;
  assign sh_lr    = w_sh_cmd.lr;
  assign sh_al    = w_sh_cmd.al;

  // Issue whenever the result register is free or being drained this cycle.
  assign w_issue = !w_empty && (!r_res_valid || res_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= 8'h00;
    end else if (w_issue) begin
      r_res_valid <= 1'b1;
      r_res_data  <= sh_dout;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;

`ifdef SHIFT_ISSUE_STATS_EN
  logic [CNT_W-1:0] r_issue_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_issue_cnt <= '0;
    else if (w_issue) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
  end

  assign issue_cnt = r_issue_cnt;
`else
  // Stats counter not built.
`endif

endmodule
